// File: rtl/seq1101_frame_tx_if.sv
// Parallel payload handshake and serial line status of the 1101 frame transmitter.
interface seq1101_frame_tx_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              x_out;
   logic              busy;
   logic              frame_done;

   // Producer of payload words, consumer of the serial line.
   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  x_out,
      input  busy,
      input  frame_done
   );

   // The transmitter itself.
   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output x_out,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/seq1101_frame_tx.sv
// Serial frame transmitter: sync word 1101, payload MSB first, even parity bit,
// followed by GAP forced idle cycles. The line idles at 0 between frames.
module seq1101_frame_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned GAP    = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   seq1101_frame_tx_if.slave bus
);

   localparam int unsigned SYNC_LEN = 4;
   localparam int unsigned CNT_MAX  = (DATA_W > GAP)
                                      ? ((DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN)
                                      : ((GAP > SYNC_LEN) ? GAP : SYNC_LEN);
   localparam int unsigned CNT_W    = $clog2(CNT_MAX);
   localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_PARITY,
      S_GAP
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [DATA_W-1:0] shreg, shreg_d;
   logic              parity, parity_d;
   logic              x_out_q, x_out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              din_ready_c;
   logic              accept_c;

   // Ready only in IDLE and out of reset; reset therefore blocks any accept.
   assign din_ready_c = (state == S_IDLE) && RESET;
   assign accept_c    = din_ready_c && bus.din_valid;

   // Next state and next line value; the counter counts down and reloads on each state entry.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      shreg_d  = shreg;
      parity_d = parity;
      x_out_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept_c) begin
               state_d  = S_SYNC;
               cnt_d    = CNT_W'(SYNC_LEN - 1);
               shreg_d  = bus.din;
               parity_d = ^bus.din;
            end
         end
         S_SYNC: begin
            x_out_d = SYNC_WORD[cnt[1:0]];
            busy_d  = 1'b1;
            if (cnt == '0) begin
               state_d = S_DATA;
               cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         S_DATA: begin
            x_out_d = shreg[DATA_W-1];
            busy_d  = 1'b1;
            shreg_d = shreg << 1;
            if (cnt == '0) begin
               state_d = S_PARITY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         S_PARITY: begin
            x_out_d = parity;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            if (GAP > 0) begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(GAP - 1);
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs; synchronous reset truncates any frame in flight.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         parity  <= 1'b0;
         x_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         shreg   <= shreg_d;
         parity  <= parity_d;
         x_out_q <= x_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.din_ready  = din_ready_c;
   assign bus.x_out      = x_out_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seq1101_frame_tx.sv
// Bench for seq1101_frame_tx: scoreboard of expected line cycles fed at each accept,
// monitor comparing every cycle, plus a DATA_W=4 / GAP=0 instance run back to back.
module tb_seq1101_frame_tx;

   localparam int unsigned DW = 8;
   localparam int unsigned GP = 2;

   typedef struct packed {
      logic x;
      logic busy;
      logic done;
   } exp_t;

   logic clk;
   logic rst;
   logic rst2;

   seq1101_frame_tx_if #(.DATA_W(DW)) bus ();
   seq1101_frame_tx_if #(.DATA_W(4))  bus2 ();

   seq1101_frame_tx #(.DATA_W(DW), .GAP(GP)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   seq1101_frame_tx #(.DATA_W(4), .GAP(0)) dut2 (
      .CLK   (clk),
      .RESET (rst2),
      .bus   (bus2)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];
   exp_t cur = '0;
   bit   run2 = 1'b0;
   int   ph2  = 0;
   int   hits2 = 0;
   logic [3:0] det2 = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a frame is a list of line cycles; ready means nothing left to send.
   always @(posedge clk) begin
      bit   acc;
      bit   sync_bits [4];
      logic [DW-1:0] d;
      cyc++;
      sync_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
      acc = (rst === 1'b1) && (bus.din_valid === 1'b1) && (q.size() == 0);
      d   = bus.din;
      if (rst !== 1'b1) begin
         q.delete();
         cur = '0;
      end else begin
         cur = (q.size() > 0) ? q.pop_front() : exp_t'('0);
         if (acc) begin
            for (int i = 0; i < 4; i++)
               q.push_back('{x: sync_bits[i], busy: 1'b1, done: 1'b0});
            for (int i = int'(DW) - 1; i >= 0; i--)
               q.push_back('{x: d[i], busy: 1'b1, done: 1'b0});
            q.push_back('{x: (($countones(d) % 2) != 0), busy: 1'b1, done: 1'b1});
            for (int i = 0; i < int'(GP); i++)
               q.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0});
         end
      end
   end

   // Monitor for the default instance, sampled mid-cycle.
   always @(negedge clk) begin
      chk("x_out", 32'(bus.x_out), 32'(cur.x));
      chk("busy", 32'(bus.busy), 32'(cur.busy));
      chk("frame_done", 32'(bus.frame_done), 32'(cur.done));
      chk("din_ready", 32'(bus.din_ready), 32'((rst === 1'b1) && (q.size() == 0)));
   end

   // Monitor for the DATA_W=4, GAP=0 instance: 10-cycle period 0 1101 1011 1.
   always @(negedge clk) begin
      bit p2x [10];
      p2x = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      if (run2) begin
         chk("w4_x_out", 32'(bus2.x_out), 32'(p2x[ph2]));
         chk("w4_busy", 32'(bus2.busy), 32'(ph2 != 0));
         chk("w4_frame_done", 32'(bus2.frame_done), 32'(ph2 == 9));
         chk("w4_din_ready", 32'(bus2.din_ready), 32'(ph2 == 9));
         det2 = {det2[2:0], bus2.x_out};
         if (det2 == 4'b1101) hits2++;
         ph2 = (ph2 == 9) ? 0 : ph2 + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Sends one word from idle and compares the 13 captured line bits to a fixed pattern.
   task automatic capture(input logic [DW-1:0] d, input logic [12:0] exp_bits, input string name);
      logic [12:0] bits;
      bits = '0;
      bus.din       = d;
      bus.din_valid = 1'b1;
      @(posedge clk);
      #2;
      bus.din_valid = 1'b0;
      repeat (13) begin
         @(posedge clk);
         @(negedge clk);
         bits = {bits[11:0], bus.x_out};
      end
      chk(name, 32'(bits), 32'(exp_bits));
   endtask

   initial begin
      rst            = 1'b0;
      rst2           = 1'b0;
      bus.din        = '0;
      bus.din_valid  = 1'b0;
      bus2.din       = 4'b1011;
      bus2.din_valid = 1'b1;
      #2;
      repeat (3) step();
      rst = 1'b1;
      repeat (3) step();

      capture(8'hA5, 13'b1101_10100101_0, "frame_a5");
      repeat (4) step();
      capture(8'h01, 13'b1101_00000001_1, "frame_01");
      repeat (4) step();

      // Valid held high, word changing every cycle: only accept-edge words are framed.
      bus.din_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bus.din = (i % 2 == 0) ? 8'hFF : 8'h00;
         step();
      end
      bus.din_valid = 1'b0;
      repeat (20) step();

      // Reset in the middle of the data field, then a clean frame right after.
      bus.din       = 8'hC3;
      bus.din_valid = 1'b1;
      step();
      bus.din_valid = 1'b0;
      repeat (7) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      capture(8'h3C, 13'b1101_00111100_0, "frame_3c_after_reset");
      repeat (4) step();

      // Reset together with valid: no accept may occur.
      rst           = 1'b0;
      bus.din       = 8'hFF;
      bus.din_valid = 1'b1;
      repeat (3) step();
      rst           = 1'b1;
      bus.din_valid = 1'b0;
      repeat (5) step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         bus.din_valid = ($urandom_range(0, 9) < 6);
         bus.din       = DW'($urandom);
         rst           = ($urandom_range(0, 49) != 0);
         step();
      end
      rst           = 1'b1;
      bus.din_valid = 1'b0;
      repeat (20) step();

      // Narrow instance with valid held high from reset release.
      rst2 = 1'b1;
      step();
      run2 = 1'b1;
      repeat (50) step();
      run2 = 1'b0;
      chk("w4_detector_hits_ge_5", 32'(hits2 >= 5), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
